// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the shared-FIFO write arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE=0, GRANT=1)
//   id_w()      : width of a writer index for a given writer count
//   cnt_w()     : width of the burst counter for a given burst length
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREQ  = 4;
   localparam int DEF_BURST = 4;

   // Writer index width; never below one bit so a 1-writer build still compiles.
   function automatic int id_w(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Burst counter must be able to hold the value BURST itself.
   function automatic int cnt_w(input int burst);
      return $clog2(burst + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin search. Starting one above i_last and
// wrapping modulo NREQ, returns the first asserted request.
//   i_req   : request vector, one bit per writer
//   i_last  : index of the writer granted most recently
//   o_found : at least one request is asserted
//   o_idx   : winning writer index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = id_w(DEF_NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_last,
   output logic            o_found,
   output logic [IDW-1:0]  o_idx
);

   int w_cand;

   // k runs 1..NREQ so the previous owner is examined last.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = (int'(i_last) + k) % NREQ;
         if (!o_found && i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = IDW'(w_cand);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter letting NREQ writers share one synchronous FIFO write
// port. A winner owns the port for up to BURST words, then one IDLE cycle is
// spent re-arbitrating.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-writer word available
//   req_data      : writer i word at [i*WIDTH +: WIDTH]
//   req_ready     : per-writer word accepted this cycle
//   fifo_full     : shared FIFO full flag
//   fifo_wr_en    : shared FIFO write strobe (combinational, zero latency)
//   fifo_data_in  : shared FIFO write data (current owner's slice)
//   grant_id      : current owner, 0 while idle
//   busy          : high while a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ,
   parameter int BURST = DEF_BURST
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [WIDTH-1:0]         fifo_data_in,
   output logic [id_w(NREQ)-1:0]    grant_id,
   output logic                     busy
);

   localparam int IDW = id_w(NREQ);
   localparam int CW  = cnt_w(BURST);

   arb_state_e       r_state;
   logic [IDW-1:0]   r_grant_id;
   logic [IDW-1:0]   r_last_grant;
   logic [CW-1:0]    r_burst_cnt;

   logic             w_found;
   logic [IDW-1:0]   w_pick;
   logic             w_own_valid;
   logic             w_grant_ready;
   logic             w_xfer;
   logic             w_last_word;

   rr_picker #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_picker (
      .i_req   (req_valid),
      .i_last  (r_last_grant),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   assign w_own_valid   = req_valid[r_grant_id];
   // rst gates the handshake so a burst interrupted by reset writes nothing
   // in the reset cycle itself, not just from the next cycle on.
   assign w_grant_ready = (r_state == GRANT) && !fifo_full && !rst;
   assign w_xfer        = w_grant_ready && w_own_valid;
   assign w_last_word   = (r_burst_cnt == CW'(BURST - 1));

   always_comb begin
      req_ready = '0;
      if (w_grant_ready)
         req_ready[r_grant_id] = 1'b1;
   end

   assign fifo_wr_en   = w_xfer;
   assign fifo_data_in = req_data[int'(r_grant_id)*WIDTH +: WIDTH];
   assign grant_id     = r_grant_id;
   assign busy         = (r_state == GRANT);

   // r_grant_id is cleared on release so grant_id reads 0 in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_grant_id   <= '0;
         r_burst_cnt  <= '0;
         r_last_grant <= IDW'(NREQ - 1);
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant_id  <= w_pick;
                  r_burst_cnt <= '0;
                  r_state     <= GRANT;
               end
            end
            GRANT: begin
               if (fifo_full) begin
                  // FIFO back-pressure freezes the grant; no timeout.
                  r_state <= GRANT;
               end else if (!w_own_valid) begin
                  r_state      <= IDLE;
                  r_last_grant <= r_grant_id;
                  r_grant_id   <= '0;
               end else begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
                  if (w_last_word) begin
                     r_state      <= IDLE;
                     r_last_grant <= r_grant_id;
                     r_grant_id   <= '0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

   localparam int W = 8;
   localparam int N = 4;
   localparam int B = 4;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*W-1:0]  req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_wr_en;
   logic [W-1:0]    fifo_data_in;
   logic [1:0]      grant_id;
   logic            busy;

   fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // writer models: word list, length, next-word pointer, enable
   logic [7:0] wdat [N][64];
   int         wlen [N];
   int         wptr [N];
   logic [N-1:0] en;

   // negedge samples
   logic         s_wr, s_busy;
   logic [7:0]   s_data;
   logic [1:0]   s_gid;
   logic [N-1:0] s_rdy, s_vld;

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive writers, sample at negedge, advance accepted writers.
   task automatic tick(input logic full);
      for (int i = 0; i < N; i++) begin
         req_valid[i] = en[i] && (wptr[i] < wlen[i]);
         req_data[i*W +: W] = (wptr[i] < wlen[i]) ? wdat[i][wptr[i]] : 8'h00;
      end
      fifo_full = full;
      @(negedge clk);
      s_wr   = fifo_wr_en;
      s_data = fifo_data_in;
      s_gid  = grant_id;
      s_busy = busy;
      s_rdy  = req_ready;
      s_vld  = req_valid;
      @(posedge clk);
      for (int i = 0; i < N; i++)
         if (s_rdy[i] && s_vld[i]) wptr[i]++;
      #1;
   endtask

   task automatic load(input int w, input int base, input int n);
      for (int j = 0; j < n; j++) wdat[w][j] = 8'(base + j);
      wlen[w] = n;
      wptr[w] = 0;
      en[w]   = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = '0;
      for (int i = 0; i < N; i++) begin
         wlen[i] = 0;
         wptr[i] = 0;
      end
      tick(1'b0);
      tick(1'b0);
      chk("rst_rdy", 32'(s_rdy), 32'h0);
      chk("rst_wr", 32'(s_wr), 32'h0);
      rst = 1'b0;
      tick(1'b0);
      chk("post_busy", 32'(s_busy), 32'h0);
      chk("post_gid", 32'(s_gid), 32'h0);
      chk("post_rdy", 32'(s_rdy), 32'h0);
   endtask

   // Per-cycle expected write/busy bits, full stimulus, written-byte list,
   // and 2-bit grant per cycle (checked as 0 when not busy).
   task automatic run_vec(input string nm, input int n, input logic [15:0] ewr,
                          input logic [15:0] ebusy, input logic [15:0] efull,
                          input logic [63:0] edl, input logic [31:0] egl);
      int k;
      k = 0;
      for (int c = 0; c < n; c++) begin
         tick(efull[c]);
         chk({nm, "_wr"}, 32'(s_wr), 32'(ewr[c]));
         chk({nm, "_busy"}, 32'(s_busy), 32'(ebusy[c]));
         chk({nm, "_gid"}, 32'(s_gid), ebusy[c] ? 32'(egl[2*c +: 2]) : 32'h0);
         if (efull[c]) chk({nm, "_rdyfull"}, 32'(s_rdy), 32'h0);
         if (ewr[c]) begin
            chk({nm, "_data"}, 32'(s_data), 32'(edl[8*k +: 8]));
            k++;
         end
      end
   endtask

   initial begin
      int sb [N];
      int total;
      int g, kk;
      logic f;

      rst = 1'b1; en = '0; fifo_full = 1'b0; req_valid = '0; req_data = '0;

      // single writer, 6 words: burst of 4, one idle, then 2
      do_reset();
      load(0, 'hA0, 6);
      run_vec("t1", 10, 16'h00DE, 16'h01DE, 16'h0000, 64'h0000_A5A4_A3A2_A1A0, 32'h0);

      // all writers valid: order 0,1,2,3,0, 4 words each, idle between
      do_reset();
      for (int i = 0; i < N; i++) load(i, i*16, 8);
      for (int c = 0; c < 25; c++) begin
         tick(1'b0);
         g = (c / 5) % 4;
         chk("t2_wr", 32'(s_wr), 32'(c % 5 != 0));
         chk("t2_busy", 32'(s_busy), 32'(c % 5 != 0));
         if (c % 5 != 0) begin
            kk = ((c / 5 >= 4) ? 4 : 0) + (c % 5) - 1;
            chk("t2_gid", 32'(s_gid), 32'(g));
            chk("t2_data", 32'(s_data), 32'(g*16 + kk));
         end
      end

      // fifo_full for 3 cycles after 2 words
      do_reset();
      load(0, 'hB0, 4);
      run_vec("t3", 9, 16'h00C6, 16'h00FE, 16'h0038, 64'hB3B2_B1B0, 32'h0);

      // owner drops after 1 word, writer 2 follows after one idle
      do_reset();
      load(0, 'hC0, 1);
      load(2, 'hE0, 2);
      run_vec("t4", 8, 16'h0032, 16'h0076, 16'h0000, 64'hE1E0C0, 32'h2A00);

      // reset mid-burst, then writers 1 and 3: writer 1 first
      do_reset();
      load(0, 'hD0, 4);
      load(1, 'hF0, 2);
      load(3, 'h30, 2);
      run_vec("t5a", 3, 16'h0006, 16'h0006, 16'h0000, 64'hD1D0, 32'h0);
      rst = 1'b1;
      tick(1'b0);
      chk("t5_rst_wr", 32'(s_wr), 32'h0);
      chk("t5_rst_rdy", 32'(s_rdy), 32'h0);
      rst = 1'b0;
      en[0] = 1'b0;
      run_vec("t5b", 3, 16'h0006, 16'h0006, 16'h0000, 64'hF1F0, 32'h14);

      // random valid/full with scoreboard
      do_reset();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < 64; j++) wdat[i][j] = 8'((i << 6) | j);
         wlen[i] = 64;
         wptr[i] = 0;
         sb[i]   = 0;
      end
      total = 0;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 4) == 0);
         tick(f);
         chk("rnd_full", 32'(s_wr && f), 32'h0);
         chk("rnd_1hot", 32'($countones(s_rdy) > 1), 32'h0);
         if (s_wr) begin
            g = int'(s_gid);
            chk("rnd_data", 32'(s_data), (sb[g] < 64) ? 32'(wdat[g][sb[g]]) : 32'hFFFF);
            sb[g]++;
            total++;
         end
      end
      for (int i = 0; i < N; i++) chk("rnd_cnt", 32'(sb[i]), 32'(wptr[i]));
      chk("rnd_any", 32'(total > 0), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
